// File: rtl/bn_pkg.sv
// Shared defaults and FSM encoding for the batch-norm parameter feeder.
package bn_pkg;

    localparam int BN_DATA_WIDTH = 32;
    localparam int BN_MAX_CH     = 64;
    localparam int BN_CH_W       = 6;
    localparam int BN_PIX_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } bn_state_t;

endpackage

// File: rtl/bn_param_rf.sv
// Per-channel {scale, bias} storage: one synchronous write port, one
// asynchronous read port. No reset, so parameters survive a frame abort.
module bn_param_rf #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_CH     = 64,
    parameter int CH_W       = 6
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [CH_W-1:0]       i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wscale,
    input  logic [DATA_WIDTH-1:0] i_wbias,
    input  logic [CH_W-1:0]       i_raddr,
    output logic [DATA_WIDTH-1:0] o_rscale,
    output logic [DATA_WIDTH-1:0] o_rbias
);

    logic [2*DATA_WIDTH-1:0] r_mem [MAX_CH];

    // Write port: scale in the upper half, bias in the lower half.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= {i_wscale, i_wbias};
        end
    end

    // Combinational read so the pair lines up with the sample accepted this cycle.
    always_comb begin
        o_rscale = r_mem[i_raddr][2*DATA_WIDTH-1:DATA_WIDTH];
        o_rbias  = r_mem[i_raddr][DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/bn_param_feeder.sv
// Feeds a channel-major sample stream to the batch-norm stage, attaching the
// per-channel A/B words. Valid-only output, one register stage of latency.
module bn_param_feeder
    import bn_pkg::*;
#(
    parameter int DATA_WIDTH = BN_DATA_WIDTH,
    parameter int MAX_CH     = BN_MAX_CH,
    parameter int CH_W       = BN_CH_W,
    parameter int PIX_W      = BN_PIX_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [CH_W-1:0]       cfg_addr,
    input  logic [DATA_WIDTH-1:0] cfg_scale,
    input  logic [DATA_WIDTH-1:0] cfg_bias,
    input  logic [CH_W:0]         cfg_num_ch,
    input  logic [PIX_W-1:0]      cfg_pix_per_ch,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] Data_A,
    output logic [DATA_WIDTH-1:0] Data_B,
    output logic [DATA_WIDTH-1:0] Data_In,
    output logic                  Valid_In,
    output logic                  busy,
    output logic                  done
);

    bn_state_t             r_state;
    logic [CH_W:0]         r_num_ch;
    logic [PIX_W-1:0]      r_pix_per_ch;
    logic [PIX_W-1:0]      r_pix_cnt;
    logic [CH_W-1:0]       r_ch_cnt;
    logic                  r_in_ready;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data_a;
    logic [DATA_WIDTH-1:0] r_data_b;
    logic [DATA_WIDTH-1:0] r_data_in;

    logic                  w_rf_we;
    logic                  w_accept;
    logic                  w_pix_wrap;
    logic                  w_ch_last;
    logic [DATA_WIDTH-1:0] w_rd_a;
    logic [DATA_WIDTH-1:0] w_rd_b;

    // Parameters only change while no frame is in flight.
    assign w_rf_we    = cfg_we && (r_state == ST_IDLE) && !r_busy;
    assign w_accept   = in_valid && r_in_ready;
    assign w_pix_wrap = (r_pix_cnt == (r_pix_per_ch - PIX_W'(1)));
    assign w_ch_last  = ({1'b0, r_ch_cnt} == (r_num_ch - (CH_W+1)'(1)));

    bn_param_rf #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_CH     (MAX_CH),
        .CH_W       (CH_W)
    ) u_rf (
        .clk      (clk),
        .i_we     (w_rf_we),
        .i_waddr  (cfg_addr),
        .i_wscale (cfg_scale),
        .i_wbias  (cfg_bias),
        .i_raddr  (r_ch_cnt),
        .o_rscale (w_rd_a),
        .o_rbias  (w_rd_b)
    );

    // Frame FSM, pixel/channel counters and the output register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_num_ch     <= '0;
            r_pix_per_ch <= '0;
            r_pix_cnt    <= '0;
            r_ch_cnt     <= '0;
            r_in_ready   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_valid      <= 1'b0;
            r_data_a     <= '0;
            r_data_b     <= '0;
            r_data_in    <= '0;
        end else begin
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_num_ch     <= cfg_num_ch;
                        r_pix_per_ch <= cfg_pix_per_ch;
                        r_pix_cnt    <= '0;
                        r_ch_cnt     <= '0;
                        r_busy       <= 1'b1;
                        if ((cfg_num_ch != '0) && (cfg_pix_per_ch != '0)) begin
                            r_state    <= ST_RUN;
                            r_in_ready <= 1'b1;
                        end else begin
                            // Empty frame: report completion without any samples.
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_valid   <= 1'b1;
                        r_data_in <= in_data;
                        r_data_a  <= w_rd_a;
                        r_data_b  <= w_rd_b;
                        if (w_pix_wrap) begin
                            r_pix_cnt <= '0;
                            r_ch_cnt  <= r_ch_cnt + CH_W'(1);
                        end else begin
                            r_pix_cnt <= r_pix_cnt + PIX_W'(1);
                        end
                        if (w_pix_wrap && w_ch_last) begin
                            r_state    <= ST_DONE;
                            r_done     <= 1'b1;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign Valid_In = r_valid;
    assign Data_A   = r_data_a;
    assign Data_B   = r_data_b;
    assign Data_In  = r_data_in;

endmodule

// File: doc/bn_param_feeder.md
# bn_param_feeder

Upstream companion of the batch-normalization stage. It holds per-channel scale (A) and bias (B) words in a small register file, accepts a channel-major feature-map stream, and issues each sample one cycle later together with its channel's A/B pair on the batch-norm input bus (`Data_A`, `Data_B`, `Data_In`, `Valid_In`). The batch-norm stage has no back-pressure, so the output is a valid-only stream. Pixel and channel counting is done here.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: IEEE-754 single word width.
- `MAX_CH`, default 64: register-file depth (channels).
- `CH_W`, default 6: log2(`MAX_CH`); width of channel index.
- `PIX_W`, default 16: width of pixels-per-channel count.

Ports. One clock; reset is asynchronous and active-high.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_we` in 1: parameter write strobe.
- `cfg_addr` in `CH_W`: channel being written.
- `cfg_scale` in `DATA_WIDTH`: A word written.
- `cfg_bias` in `DATA_WIDTH`: B word written.
- `cfg_num_ch` in `CH_W`+1: channels per frame, 0..`MAX_CH`.
- `cfg_pix_per_ch` in `PIX_W`: samples per channel.
- `start` in 1: frame start pulse.
- `in_valid` in 1: input sample valid.
- `in_data` in `DATA_WIDTH`: input sample.
- `in_ready` out 1: high only in RUN.
- `Data_A` out `DATA_WIDTH`: scale for the current output sample.
- `Data_B` out `DATA_WIDTH`: bias for the current output sample.
- `Data_In` out `DATA_WIDTH`: sample forwarded to batch norm.
- `Valid_In` out 1: output sample valid.
- `busy` out 1: high in RUN and DONE.
- `done` out 1: one-cycle pulse at frame end.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE to RUN when `start`=1 and both latched counts are nonzero.
  - IDLE to DONE when `start`=1 and either count is 0.
  - RUN to DONE on acceptance of the last pixel of the last channel.
  - DONE to IDLE unconditionally after one cycle.
- On `start` in IDLE: latch `cfg_num_ch` and `cfg_pix_per_ch`; clear `pix_cnt` and `ch_cnt` to 0. `start` is ignored outside IDLE.
- Acceptance: a sample is accepted on a cycle with `in_valid` && `in_ready`.
- Per accepted sample:
  - If `pix_cnt` equals pix_per_ch−1: `pix_cnt` goes to 0 and `ch_cnt` increments.
  - Otherwise `pix_cnt` increments.
  - Last sample of the frame: `ch_cnt` equals num_ch−1 and `pix_cnt` equals pix_per_ch−1.
- Register file:
  - Written in IDLE only; `cfg_we` is ignored while `busy`.
  - `cfg_addr` ≥ `MAX_CH` cannot occur, since the width is exact.
  - Contents are not cleared by `rst`; they are retained across reset.
- The read address is `ch_cnt`. The A/B pair must match the channel of the sample being accepted in that cycle, so an asynchronous read (or equivalent) is required.
- No arithmetic on data words; pure forwarding.

## Timing
- Reset values:
  - `Data_A`, `Data_B`, `Data_In` = 0.
  - `Valid_In`, `in_ready`, `busy`, `done` = 0.
  - State = IDLE; counters = 0.
- Latency: sample accepted at cycle N appears on `Data_In` with `Valid_In`=1 at cycle N+1.
- `Valid_In` is 0 on every cycle not preceded by an acceptance. The data outputs hold their last value when `Valid_In`=0.
- Bubbles: `in_valid` gaps produce matching `Valid_In` gaps; counters hold.
- `done` is asserted in the DONE cycle. This is the same cycle as the final `Valid_In` when the last sample is accepted in the preceding cycle.
- `in_ready` drops the cycle after the last acceptance.
- `busy` = 1 in RUN and DONE. It falls in the cycle after `done`.
- Zero-count frame: `start` → next cycle `done`=1, no `Valid_In`.
- `rst` mid-frame: immediate IDLE with all outputs at reset values. The in-flight registered sample is dropped, and the next frame restarts at channel 0.

## Structure
- Shared package `bn_pkg` holds:
  - `DATA_WIDTH`, `MAX_CH`, `CH_W` and `PIX_W` defaults.
  - The state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
- Sub-module `bn_param_rf`: `MAX_CH`×(2·`DATA_WIDTH`) register file with one synchronous write port and one asynchronous read port, no reset.
- Top level contains the FSM, the two counters and the output register stage.

## Test plan
- Load ch0 A=0x40000000 (2.0), B=0x3F800000 (1.0), then `start` with num_ch=1, pix=1, and drive `in_data`=0x3F800000 → one `Valid_In` one cycle after acceptance with those values, and `done` in the same cycle.
- Load ch0 A=0x40000000, ch1 A=0x40400000 (3.0); num_ch=2, pix=3; six back-to-back samples → A = 2.0,2.0,2.0,3.0,3.0,3.0, then `done`, then `busy` falls.
- Same frame with `in_valid` deasserted on alternate cycles → identical output sequence with one-cycle gaps in `Valid_In`.
- num_ch=0 (also pix=0) → `done` the cycle after `start`, `Valid_In` never asserted.
- `cfg_we` to ch0 with A=0xC0000000 during RUN → outputs keep 2.0, and a readback in the next frame still gives 2.0.
- Assert `rst` after the 4th sample of a 2×3 frame → all outputs 0 the same cycle. Restart → the first output uses ch0 parameters, and parameters survive the reset.
